// File: rtl/radio_pkg.sv
// Shared constants and sign-extension helpers for the radio audio input path.
package radio_pkg;

    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned MAX_LOG2     = 15;
    localparam int unsigned DEFAULT_LOG2 = 0;
    localparam int unsigned ACC_WIDTH    = SAMPLE_WIDTH + MAX_LOG2;
    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned LOG2_WIDTH   = $clog2(MAX_LOG2 + 1);
    localparam int unsigned COUNT_WIDTH  = MAX_LOG2;

    function automatic logic [ACC_WIDTH-1:0] sext_sample(input logic [SAMPLE_WIDTH-1:0] s);
        return ACC_WIDTH'($signed(s));
    endfunction

    // The shifted average always fits in SAMPLE_WIDTH, so extending the full accumulator is exact.
    function automatic logic [WORD_WIDTH-1:0] sext_acc(input logic [ACC_WIDTH-1:0] a);
        return WORD_WIDTH'($signed(a));
    endfunction

endpackage

// File: rtl/stream_holding_reg.sv
// Single-entry stb/ack output buffer; a load arriving while full and not draining is dropped and flagged.
module stream_holding_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             stb_o,
    input  logic             ack_i,
    output logic             overflow_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             stb_q, stb_d;
    logic             ovf_q, ovf_d;
    logic             drain_c;

    always_comb begin
        data_d  = data_q;
        stb_d   = stb_q;
        ovf_d   = ovf_q;
        drain_c = stb_q && ack_i;
        if (load_i && (!stb_q || drain_c)) begin
            data_d = data_i;
            stb_d  = 1'b1;
        end else begin
            if (drain_c) begin
                stb_d = 1'b0;
            end
            if (load_i) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            stb_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            stb_q  <= stb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign stb_o      = stb_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/radio_audio_averager.sv
// Averages blocks of 2^L signed radio samples and streams each average as a 32-bit word.
module radio_audio_averager
    import radio_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] input_sample,
    input  logic                    input_sample_valid,
    input  logic [WORD_WIDTH-1:0]   input_average_samples,
    input  logic                    input_average_samples_stb,
    output logic                    input_average_samples_ack,
    output logic [WORD_WIDTH-1:0]   output_audio,
    output logic                    output_audio_stb,
    input  logic                    output_audio_ack,
    output logic                    overflow
);

    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [LOG2_WIDTH-1:0]  log2_q, log2_d;
    logic                   cfg_ack_q, cfg_ack_d;

    logic                   cfg_xfer_c;
    logic                   block_done_c;
    logic [ACC_WIDTH-1:0]   sum_c;
    logic [COUNT_WIDTH-1:0] last_count_c;
    logic [WORD_WIDTH-1:0]  result_c;

    // Config handshake, accumulation and block completion; a config transfer pre-empts a sample.
    always_comb begin
        acc_d        = acc_q;
        count_d      = count_q;
        log2_d       = log2_q;
        block_done_c = 1'b0;
        cfg_xfer_c   = input_average_samples_stb && cfg_ack_q;
        cfg_ack_d    = input_average_samples_stb && !cfg_ack_q;
        sum_c        = acc_q + sext_sample(input_sample);
        last_count_c = (COUNT_WIDTH'(1) << log2_q) - COUNT_WIDTH'(1);
        result_c     = sext_acc(ACC_WIDTH'($signed(sum_c) >>> log2_q));

        if (cfg_xfer_c) begin
            acc_d   = '0;
            count_d = '0;
            log2_d  = (input_average_samples > WORD_WIDTH'(MAX_LOG2))
                      ? LOG2_WIDTH'(MAX_LOG2)
                      : input_average_samples[LOG2_WIDTH-1:0];
        end else if (input_sample_valid) begin
            if (count_q == last_count_c) begin
                block_done_c = 1'b1;
                acc_d        = '0;
                count_d      = '0;
            end else begin
                acc_d   = sum_c;
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            count_q   <= '0;
            log2_q    <= LOG2_WIDTH'(DEFAULT_LOG2);
            cfg_ack_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            count_q   <= count_d;
            log2_q    <= log2_d;
            cfg_ack_q <= cfg_ack_d;
        end
    end

    assign input_average_samples_ack = cfg_ack_q;

    stream_holding_reg #(
        .WIDTH (WORD_WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (block_done_c),
        .data_i     (result_c),
        .data_o     (output_audio),
        .stb_o      (output_audio_stb),
        .ack_i      (output_audio_ack),
        .overflow_o (overflow)
    );

endmodule

// File: tb/tb_radio_audio_averager.sv
// Bench for radio_audio_averager: directed vector table, long corner sequences and random traffic vs a block-average model.
module tb_radio_audio_averager;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] input_sample;
    logic        input_sample_valid;
    logic [31:0] input_average_samples;
    logic        input_average_samples_stb;
    logic        input_average_samples_ack;
    logic [31:0] output_audio;
    logic        output_audio_stb;
    logic        output_audio_ack;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit xf;

    // Reference model state: current block sum/length, buffered word, config ack pulse.
    int          m_L;
    longint      m_sum;
    int          m_n;
    bit          m_full;
    logic [31:0] m_word;
    bit          m_ovf;
    bit          m_ack;

    typedef struct {
        bit          v;
        logic [15:0] s;
        bit          cs;
        logic [31:0] cfg;
        bit          ack;
        bit          e_stb;
        logic [31:0] e_audio;
        bit          e_ovf;
    } vec_t;

    vec_t vecs[$];

    radio_audio_averager dut (
        .clk                       (clk),
        .rst                       (rst),
        .input_sample              (input_sample),
        .input_sample_valid        (input_sample_valid),
        .input_average_samples     (input_average_samples),
        .input_average_samples_stb (input_average_samples_stb),
        .input_average_samples_ack (input_average_samples_ack),
        .output_audio              (output_audio),
        .output_audio_stb          (output_audio_stb),
        .output_audio_ack          (output_audio_ack),
        .overflow                  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint num, input longint den);
        longint q;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    function automatic vec_t mk(input bit v, input logic [15:0] s, input bit cs, input logic [31:0] cfg,
                                input bit ack, input bit es, input logic [31:0] ea, input bit eo);
        vec_t r;
        r.v = v; r.s = s; r.cs = cs; r.cfg = cfg; r.ack = ack;
        r.e_stb = es; r.e_audio = ea; r.e_ovf = eo;
        return r;
    endfunction

    task automatic model_reset();
        m_L = 0; m_sum = 0; m_n = 0; m_full = 0; m_word = '0; m_ovf = 0; m_ack = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] s, input bit cs, input logic [31:0] cfg,
                              input bit oack, output bit xfer);
        bit     done;
        longint res;
        bit     drain;
        done = 0;
        res  = 0;
        xfer = cs && m_ack;
        if (xfer) begin
            m_L   = (cfg > 32'd15) ? 15 : int'(cfg);
            m_sum = 0;
            m_n   = 0;
        end else if (v) begin
            m_sum = m_sum + longint'($signed(s));
            m_n   = m_n + 1;
            if (m_n == (1 << m_L)) begin
                done  = 1;
                res   = floor_div(m_sum, longint'(1) << m_L);
                m_sum = 0;
                m_n   = 0;
            end
        end
        drain = m_full && oack;
        if (drain) m_full = 0;
        if (done) begin
            if (m_full) m_ovf = 1;
            else begin
                m_word = res[31:0];
                m_full = 1;
            end
        end
        m_ack = cs && !m_ack;
    endtask

    // One clock: drive at negedge, model at posedge, compare at the following negedge.
    task automatic cycle(input bit v, input logic [15:0] s, input bit cs, input logic [31:0] cfg,
                         input bit oack, output bit xfer);
        input_sample_valid        = v;
        input_sample              = s;
        input_average_samples_stb = cs;
        input_average_samples     = cfg;
        output_audio_ack          = oack;
        @(posedge clk);
        model_step(v, s, cs, cfg, oack, xfer);
        @(negedge clk);
        check("model", {input_average_samples_ack, overflow, output_audio_stb, output_audio},
                       {m_ack, m_ovf, m_full, m_word});
    endtask

    task automatic set_cfg(input logic [31:0] val, input bit oack);
        int waited;
        bit x;
        waited = 0;
        while (!input_average_samples_ack && waited < 6) begin
            cycle(0, 16'd0, 1, val, oack, x);
            waited++;
        end
        check("cfg_ack_seen", 64'(input_average_samples_ack), 64'd1);
        cycle(0, 16'd0, 1, val, oack, x);
    endtask

    task automatic do_reset();
        input_sample_valid        = 0;
        input_sample              = '0;
        input_average_samples_stb = 0;
        input_average_samples     = '0;
        output_audio_ack          = 0;
        rst = 0;
        #1;
        check("async_reset", {input_average_samples_ack, overflow, output_audio_stb, output_audio}, 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    initial begin
        bit          pend;
        logic [31:0] pcfg;
        int          stb_seen;

        rst = 0;
        input_sample_valid        = 0;
        input_sample              = '0;
        input_average_samples_stb = 0;
        input_average_samples     = '0;
        output_audio_ack          = 0;
        model_reset();

        // Reset held for five cycles, then a pass-through sample at the default L.
        repeat (5) begin
            @(negedge clk);
            check("reset_hold", {input_average_samples_ack, overflow, output_audio_stb, output_audio}, 64'd0);
        end
        rst = 1;
        cycle(1, 16'h1234, 0, 0, 0, xf);
        check("reset_first_word", {output_audio_stb, output_audio}, {1'b1, 32'h0000_1234});
        cycle(0, 16'd0, 0, 0, 1, xf);
        check("reset_first_drain", 64'(output_audio_stb), 64'd0);

        // L=2 block average.
        vecs.push_back(mk(0, 16'd0,    1, 32'd2, 1, 0, 32'd0, 0));
        vecs.push_back(mk(0, 16'd0,    1, 32'd2, 1, 0, 32'd0, 0));
        vecs.push_back(mk(1, 16'd4,    0, 32'd0, 1, 0, 32'd0, 0));
        vecs.push_back(mk(1, 16'd8,    0, 32'd0, 1, 0, 32'd0, 0));
        vecs.push_back(mk(1, 16'hFFFC, 0, 32'd0, 1, 0, 32'd0, 0));
        vecs.push_back(mk(1, 16'd12,   0, 32'd0, 1, 1, 32'h0000_0005, 0));
        vecs.push_back(mk(0, 16'd0,    0, 32'd0, 1, 0, 32'd0, 0));
        // L=1 negative rounding toward minus infinity.
        vecs.push_back(mk(0, 16'd0,    1, 32'd1, 1, 0, 32'd0, 0));
        vecs.push_back(mk(0, 16'd0,    1, 32'd1, 1, 0, 32'd0, 0));
        vecs.push_back(mk(1, 16'hFFFD, 0, 32'd0, 1, 0, 32'd0, 0));
        vecs.push_back(mk(1, 16'd0,    0, 32'd0, 1, 1, 32'hFFFF_FFFE, 0));
        vecs.push_back(mk(0, 16'd0,    0, 32'd0, 1, 0, 32'd0, 0));
        // L=0 back-to-back drain and load.
        vecs.push_back(mk(0, 16'd0,    1, 32'd0, 1, 0, 32'd0, 0));
        vecs.push_back(mk(0, 16'd0,    1, 32'd0, 1, 0, 32'd0, 0));
        vecs.push_back(mk(1, 16'd10,   0, 32'd0, 1, 1, 32'd10, 0));
        vecs.push_back(mk(1, 16'd11,   0, 32'd0, 1, 1, 32'd11, 0));
        vecs.push_back(mk(1, 16'd12,   0, 32'd0, 1, 1, 32'd12, 0));
        vecs.push_back(mk(0, 16'd0,    0, 32'd0, 1, 0, 32'd0, 0));
        // Backpressure: second word dropped, overflow sticks.
        vecs.push_back(mk(1, 16'd1,    0, 32'd0, 0, 1, 32'd1, 0));
        vecs.push_back(mk(1, 16'd2,    0, 32'd0, 0, 1, 32'd1, 1));
        vecs.push_back(mk(0, 16'd0,    0, 32'd0, 0, 1, 32'd1, 1));
        vecs.push_back(mk(0, 16'd0,    0, 32'd0, 1, 0, 32'd0, 1));
        vecs.push_back(mk(0, 16'd0,    0, 32'd0, 1, 0, 32'd0, 1));

        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].s, vecs[i].cs, vecs[i].cfg, vecs[i].ack, xf);
            check($sformatf("vec[%0d]", i),
                  {overflow, output_audio_stb, (vecs[i].e_stb ? output_audio : 32'd0)},
                  {vecs[i].e_ovf, vecs[i].e_stb, vecs[i].e_audio});
        end

        // Random traffic against the model.
        do_reset();
        pend = 0;
        pcfg = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend && $urandom_range(0, 15) == 0) begin
                pend = 1;
                pcfg = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
            end
            cycle($urandom_range(0, 3) != 0, 16'($urandom), pend, pcfg, $urandom_range(0, 2) != 0, xf);
            if (xf) pend = 0;
        end

        // Reset mid-block with a word buffered discards both.
        do_reset();
        cycle(1, 16'd9, 0, 0, 0, xf);
        set_cfg(32'd2, 0);
        repeat (3) cycle(1, 16'd1000, 0, 0, 0, xf);
        check("buffered_hold", {output_audio_stb, output_audio}, {1'b1, 32'd9});
        do_reset();
        cycle(1, 16'd7, 0, 0, 1, xf);
        check("post_reset_word", {output_audio_stb, output_audio}, {1'b1, 32'd7});
        cycle(0, 16'd0, 0, 0, 1, xf);

        // Largest block of most negative samples.
        set_cfg(32'd15, 1);
        repeat (32768) cycle(1, 16'h8000, 0, 0, 1, xf);
        check("max_neg", {overflow, output_audio_stb, output_audio}, {1'b0, 1'b1, 32'hFFFF_8000});
        cycle(0, 16'd0, 0, 0, 1, xf);

        // Oversized config coinciding with a sample: clamps to 15 and discards that sample.
        set_cfg(32'd3, 1);
        repeat (4) cycle(1, 16'd7, 0, 0, 1, xf);
        cycle(1, 16'd7, 1, 32'd40, 1, xf);
        cycle(1, 16'h7FFF, 1, 32'd40, 1, xf);
        stb_seen = 0;
        for (int i = 0; i < 32767; i++) begin
            cycle(1, 16'd7, 0, 0, 1, xf);
            if (output_audio_stb) stb_seen++;
        end
        check("midcfg_no_early_word", 64'(stb_seen), 64'd0);
        cycle(1, 16'd7, 0, 0, 1, xf);
        check("midcfg_word", {output_audio_stb, output_audio}, {1'b1, 32'd7});
        cycle(0, 16'd0, 0, 0, 1, xf);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
